// File: rtl/ex_mem_stage.sv
// EX stage (operand forwarding, ALU, optional shift-add multiplier) and the EX/MEM register.
// Build with `define EX_MUL_EN to include the multiplier; without it MUL passes through with ALUOut = 0.
module ex_mem_stage #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_ex_valid,
    input  logic [4:0]         ID_EX_RegRd,
    input  logic [4:0]         ID_EX_RegRt,
    input  logic               ID_EX_RegWrite,
    input  logic               ID_EX_MemWrite,
    input  logic               ID_EX_MemRead,
    input  logic               ID_EX_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_EX_ALUOp,
    input  logic               ID_EX_Mul,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [WIDTH-1:0]   imm_ext,
    input  logic [1:0]         ForwardA,
    input  logic [1:0]         ForwardB,
    input  logic [WIDTH-1:0]   MEM_WB_WriteData,
    input  logic               mem_stall,
    input  logic               flush,
    output logic               EX_MEM_valid,
    output logic               EX_MEM_RegWrite,
    output logic [4:0]         EX_MEM_RegRd,
    output logic               EX_MEM_MEMWrite,
    output logic               EX_MEM_MemRead,
    output logic [4:0]         EX_MEM_RegRt,
    output logic [WIDTH-1:0]   EX_MEM_ALUOut,
    output logic [WIDTH-1:0]   EX_MEM_WriteData,
    output logic               ex_stall
);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] OP_LUI  = ALUOP_W'(11);

    logic [WIDTH-1:0] opA, fwdB, opB, aluResult, resultVal;
    logic [4:0]       shamt;
    logic             bubble;

    function automatic logic [WIDTH-1:0] fwdSel(input logic [1:0] sel, input logic [WIDTH-1:0] regVal,
                                                 input logic [WIDTH-1:0] exMem, input logic [WIDTH-1:0] memWb);
        case (sel)
            2'b10:   return exMem;
            2'b01:   return memWb;
            default: return regVal;
        endcase
    endfunction

    always_comb begin
        opA   = fwdSel(ForwardA, rs_data, EX_MEM_ALUOut, MEM_WB_WriteData);
        fwdB  = fwdSel(ForwardB, rt_data, EX_MEM_ALUOut, MEM_WB_WriteData);
        opB   = ID_EX_ALUSrc ? imm_ext : fwdB;
        shamt = opB[4:0];
    end

    always_comb begin
        aluResult = '0;
        case (ID_EX_ALUOp)
            OP_ADD:  aluResult = opA + opB;
            OP_SUB:  aluResult = opA - opB;
            OP_AND:  aluResult = opA & opB;
            OP_OR:   aluResult = opA | opB;
            OP_XOR:  aluResult = opA ^ opB;
            OP_NOR:  aluResult = ~(opA | opB);
            OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (opA < opB)};
            OP_SLL:  aluResult = opA << shamt;
            OP_SRL:  aluResult = opA >> shamt;
            OP_SRA:  aluResult = $signed(opA) >>> shamt;
            OP_LUI:  aluResult = opB << 16;
            default: aluResult = '0;
        endcase
    end

`ifdef EX_MUL_EN
    // state | meaning
    // IDLE  | ALU path; a valid MUL here starts the multiplier
    // BUSY  | one shift-add step per cycle, WIDTH steps
    // DONE  | product ready, written to EX/MEM once MEM accepts
    localparam int CNT_W = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, nextState;
    logic [CNT_W-1:0] mulCnt;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic             start, mulHold, mulDone;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (!mem_stall) begin
            case (state)
                IDLE:    if (start) nextState = BUSY;
                BUSY:    if (flush) nextState = IDLE;
                         else if (mulCnt == CNT_W'(1)) nextState = DONE;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        start    = (state == IDLE) && id_ex_valid && ID_EX_Mul && !mem_stall && !flush;
        mulHold  = start || (state == BUSY);
        mulDone  = (state == DONE);
        // a flushed multiply frees the upstream stages in the same cycle
        ex_stall = reset ? 1'b0 : (mem_stall || start || ((state == BUSY) && !flush));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mulCnt <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (!mem_stall) begin
            if (start) begin
                mcand  <= opA;
                mplier <= fwdB;
                acc    <= '0;
                mulCnt <= CNT_W'(WIDTH);
            end else if (state == BUSY) begin
                if (flush) begin
                    mulCnt <= '0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    mulCnt <= mulCnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        resultVal = mulDone ? acc : aluResult;
        bubble    = flush || mulHold || !id_ex_valid;
    end
`else
    always_comb begin
        resultVal = ID_EX_Mul ? '0 : aluResult;
        bubble    = flush || !id_ex_valid;
        ex_stall  = reset ? 1'b0 : mem_stall;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_MEM_valid     <= 1'b0;
            EX_MEM_RegWrite  <= 1'b0;
            EX_MEM_RegRd     <= '0;
            EX_MEM_MEMWrite  <= 1'b0;
            EX_MEM_MemRead   <= 1'b0;
            EX_MEM_RegRt     <= '0;
            EX_MEM_ALUOut    <= '0;
            EX_MEM_WriteData <= '0;
        end else if (!mem_stall) begin
            EX_MEM_RegRd     <= ID_EX_RegRd;
            EX_MEM_RegRt     <= ID_EX_RegRt;
            EX_MEM_ALUOut    <= resultVal;
            EX_MEM_WriteData <= fwdB;
            EX_MEM_valid     <= !bubble;
            EX_MEM_RegWrite  <= !bubble && ID_EX_RegWrite;
            EX_MEM_MEMWrite  <= !bubble && ID_EX_MemWrite;
            EX_MEM_MemRead   <= !bubble && ID_EX_MemRead;
        end
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX stage datapath plus EX/MEM pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the forwarding unit.
- Applies the ForwardA/ForwardB operand selects.
- Runs the ALU, or an iterative multiplier for MUL.
- Registers the EX/MEM fields that the forwarding unit and the MEM stage consume: RegWrite, RegRd, MEMWrite, RegRt, ALUOut, write data.
- Raises a stall toward IF/ID/ID-EX while a multiply is in flight or MEM stalls.

Parameters:
WIDTH, 32, datapath width; also the number of multiplier iteration cycles
ALUOP_W, 4, width of alu_op

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
id_ex_valid  in  1  ID/EX holds a real instruction
ID_EX_RegRd  in  5  destination register
ID_EX_RegRt  in  5  rt index, carried for store forwarding
ID_EX_RegWrite  in  1  instruction writes the register file
ID_EX_MemWrite  in  1  store
ID_EX_MemRead  in  1  load
ID_EX_ALUSrc  in  1  1: operand B = imm; 0: forwarded rt
ID_EX_ALUOp  in  ALUOP_W  ALU operation
ID_EX_Mul  in  1  multiply, low WIDTH bits of the product
rs_data  in  WIDTH  register-file rs value
rt_data  in  WIDTH  register-file rt value
imm_ext  in  WIDTH  extended immediate
ForwardA  in  2  00 reg, 10 EX/MEM ALUOut, 01 MEM/WB data, 11 = 00
ForwardB  in  2  same encoding, applied to rt
MEM_WB_WriteData  in  WIDTH  writeback value for forwarding
mem_stall  in  1  MEM stage cannot accept; hold everything
flush  in  1  kill the instruction currently in EX
EX_MEM_valid  out  1  EX/MEM holds a real instruction
EX_MEM_RegWrite  out  1  registered
EX_MEM_RegRd  out  5  registered
EX_MEM_MEMWrite  out  1  registered
EX_MEM_MemRead  out  1  registered
EX_MEM_RegRt  out  5  registered
EX_MEM_ALUOut  out  WIDTH  registered ALU or multiply result
EX_MEM_WriteData  out  WIDTH  registered forwarded rt (store data)
ex_stall  out  1  combinational; upstream holds IF/ID and ID/EX when 1

Behaviour:
- Reset (async): all EX/MEM outputs 0, FSM IDLE, iteration counter 0. ex_stall = 0 while reset is high.
- Operand muxing:
  - opA = fwd(ForwardA, rs_data). Sources: EX_MEM_ALUOut (10), MEM_WB_WriteData (01), otherwise the register value.
  - fwdB = fwd(ForwardB, rt_data); opB = ID_EX_ALUSrc ? imm_ext : fwdB.
- ALU ops, all results WIDTH bits with wrap-around:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT signed, 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA; shift amount = opB[4:0], value = opA.
  - 11 LUI = opB << 16.
  - 12-15: result 0.
- Non-mul advance (FSM IDLE, mem_stall=0, flush=0): EX/MEM loads all fields at the edge; 1-cycle latency. Invalid input loads a bubble: valid, RegWrite, MEMWrite, MemRead = 0.
- FSM IDLE/BUSY/DONE:
  - IDLE: valid & Mul & !mem_stall & !flush → capture opA/fwdB (forwarded values are sampled only here), clear accumulator, counter=WIDTH, go BUSY. ex_stall=1 in this cycle, and EX/MEM loads a bubble.
  - BUSY: one shift-add step per cycle, counter decrements. Leave for DONE after the step with counter==1, so BUSY lasts exactly WIDTH cycles. ex_stall=1; EX/MEM loads bubbles.
  - DONE: ex_stall=mem_stall. If !mem_stall, EX/MEM loads the mul instruction with ALUOut = product, and the FSM goes to IDLE. Total EX occupancy = WIDTH+2 cycles.
- mem_stall=1:
  - EX/MEM and FSM/counter/accumulator hold.
  - ex_stall=1.
  - mem_stall has priority; flush is ignored that cycle, and the controller holds flush until accepted.
- flush=1 with mem_stall=0:
  - EX/MEM loads a bubble.
  - BUSY or DONE aborts to IDLE with no result written.
  - ex_stall=0 that cycle.
- ex_stall = reset ? 0 : (mem_stall | start | BUSY).
- Register 0: passed through unchanged. Suppressing writes is the consumer's job.

Optional Feature:
EX_MUL_EN:
- Defined: the multiplier FSM exists as above.
- Undefined: no FSM. ID_EX_Mul instructions pass through in 1 cycle with ALUOut=0 and otherwise normal control. ex_stall = mem_stall.

Test Plan:
1. ADD, rs_data=5, rt_data=7, ForwardA=ForwardB=00 → next edge: ALUOut=12, RegWrite=1, valid=1, ex_stall=0.
2. ForwardA=10 with EX_MEM_ALUOut=0x10, ForwardB=01 with MEM_WB_WriteData=3, SUB → ALUOut=0x0D. Then ForwardA=11 with rs_data=9 → opA=9.
3. Store, ALUSrc=1, imm=4, rs=0x100, ForwardB=01 with MEM_WB_WriteData=0xAB → ALUOut=0x104, WriteData=0xAB, MEMWrite=1, RegWrite=0.
4. MUL 0xFFFF_FFFF×3, WIDTH=32:
   - ex_stall=1 for exactly 33 cycles.
   - EX/MEM valid=0 during the stall.
   - ALUOut=0xFFFF_FFFD one edge after DONE.
5. MUL started, flush at BUSY cycle 10 → FSM IDLE next edge, no result, ex_stall=0. A following ADD completes normally.
6. mem_stall=1 for 3 cycles mid-BUSY, then reset asserted mid-BUSY:
   - Stall: counter frozen; completion delayed by exactly 3 cycles.
   - Reset: all outputs 0 immediately; ex_stall=0.
